cam_table: RTL
==============

CAM_TABLE -- requirements
Module: cam_table

Interface
REQ-001 SHALL have parameter INDEX_WIDTH, default 3, meaning entry index width.
REQ-002 SHALL have parameter KEY_WIDTH, default 10, meaning key width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, meaning payload width.
REQ-004 SHALL have parameter SLOTS, default 1<<INDEX_WIDTH, meaning entry count.
REQ-005 SHALL have these ports:
- clock  input  1  sole clock.
- reset  input  1  asynchronous, active-high.
- insert_valid  input  1  insert/update request.
- insert_ready  output  1  table can accept an insert.
- insert_key  input  KEY_WIDTH  key to insert.
- insert_data  input  DATA_WIDTH  payload to insert.
- lookup_valid  input  1  lookup request.
- lookup_key  input  KEY_WIDTH  key to search.
- result_valid  output  1  lookup result present.
- result_hit  output  1  key found.
- result_index  output  INDEX_WIDTH  slot of hit.
- result_data  output  DATA_WIDTH  payload of hit.
- invalidate_valid  input  1  clear one slot.
- invalidate_index  input  INDEX_WIDTH  slot to clear.
- flush  input  1  clear all slots.
- full  output  1  all slots valid.
- empty  output  1  no slot valid.
- count  output  INDEX_WIDTH+1  valid slot count.
REQ-006 Timing and reset SHALL be exactly: one clock; reset is asynchronous and active-high.

Function
REQ-007 Per slot, the block SHALL store registers valid, key[KEY_WIDTH] and data[DATA_WIDTH].
REQ-008 An insert SHALL be accepted on a rising edge where insert_valid && insert_ready.
REQ-009 If insert_key matches a valid slot, an accepted insert SHALL overwrite that slot's data; on multiple matches, the highest-index match is overwritten.
REQ-010 Otherwise, an accepted insert SHALL write key/data into the lowest-index invalid slot and set its valid bit.
REQ-011 insert_ready SHALL be combinational: (!full || insert key matches a valid slot) && !flush.
REQ-012 Lookup latency SHALL be 1 cycle: lookup_valid in cycle N gives result_valid=1 in cycle N+1.
- result_hit/result_index/result_data reflect slot state before any same-edge insert/invalidate.
REQ-013 On a miss, result_hit, result_index and result_data SHALL be 0.
REQ-014 result_valid SHALL be 0 in any cycle not following a lookup_valid cycle; other result fields hold their last values.
REQ-015 invalidate_valid SHALL clear valid[invalidate_index] at the edge; invalidating an already-invalid slot has no effect.
REQ-016 Invalidate and insert targeting the same slot on the same edge SHALL resolve with insert winning (slot ends valid with new contents).
REQ-017 flush SHALL clear all valid bits at the edge and override insert and invalidate; it does not suppress a concurrent lookup result.
REQ-018 count SHALL equal the popcount of valid bits.
- full = (count == SLOTS); empty = (count == 0).
- All are registered-state-derived, with no combinational path from inputs.
REQ-019 Only slot valid bits and result registers SHALL be reset; key/data storage need not be reset.

Reset
REQ-020 While reset is high, all valid bits SHALL be 0, and result_valid, result_hit, result_index, result_data and count SHALL be 0.
- empty=1, full=0, insert_ready=1.
REQ-021 Reset asserted mid-operation SHALL discard in-flight lookups; no result_valid is produced for a lookup issued in the cycle reset asserts.

Structure
REQ-022 Key match and index encoding SHALL use two instances of sub-module matching_encoder: one for lookup_key, one for insert_key.
REQ-023 The free-slot search SHALL be a lowest-index priority encoder over ~valid, implemented in cam_table.
REQ-024 No shared package is required; SLOTS-derived widths SHALL be local parameters.

Verification
REQ-025 Reset, then insert keys 0x011, 0x022, 0x033 -> slots 0, 1, 2 valid; count=3; empty=0.
REQ-026 Lookup 0x022 -> next cycle result_valid=1, hit=1, index=1, data as written; lookup 0x044 -> hit=0, index=0, data=0.
REQ-027 Fill all 8 slots -> full=1, insert_ready=0 for a new key, insert_ready=1 for an existing key; update of key in slot 5 changes data only, count stays 8.
REQ-028 Invalidate slot 3 with same-cycle lookup of slot-3 key -> result hit=1 (old state); next insert lands in slot 3.
REQ-029 Same-edge insert and invalidate on slot 0 -> slot 0 valid with new data; flush with insert_valid=1 -> count=0, insert_ready=0 that cycle.
REQ-030 Assert reset asynchronously mid-cycle with table half full and lookup pending -> outputs zero immediately, no result_valid after release.

Source files
------------

// File: rtl/cam_table_pkg.sv
// Default geometry for the content-addressable table. The module-specific
// widths derived from SLOTS are local parameters inside each module.
package cam_table_pkg;
  localparam int DEF_INDEX_WIDTH = 3;
  localparam int DEF_KEY_WIDTH   = 10;
  localparam int DEF_DATA_WIDTH  = 32;
endpackage

// File: rtl/cam_table_matching_encoder.sv
// Compares one key against every valid slot.
// On multiple matches it reports the highest-index slot.
module matching_encoder
  import cam_table_pkg::*;
#(
  parameter int SLOTS       = 1 << DEF_INDEX_WIDTH,
  parameter int KEY_WIDTH   = DEF_KEY_WIDTH,
  parameter int INDEX_WIDTH = DEF_INDEX_WIDTH
) (
  input  logic [KEY_WIDTH-1:0]            key,
  input  logic [SLOTS-1:0]                slot_valid,
  input  logic [SLOTS-1:0][KEY_WIDTH-1:0] slot_keys,
  output logic                            hit,
  output logic [INDEX_WIDTH-1:0]          index
);
  logic [SLOTS-1:0] match;

  generate
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_match
      assign match[gi] = slot_valid[gi] && (slot_keys[gi] == key);
    end
  endgenerate

  // Ascending scan, so a later (higher) match overrides an earlier one.
  always_comb begin
    hit   = |match;
    index = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (match[i]) index = INDEX_WIDTH'(i);
    end
  end
endmodule

// File: rtl/cam_table.sv
// Small fully-associative key/data table with insert/update, one-cycle lookup,
// single-slot invalidate and whole-table flush.
module cam_table
  import cam_table_pkg::*;
#(
  parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
  parameter int KEY_WIDTH   = DEF_KEY_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int SLOTS       = 1 << INDEX_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   insert_valid,
  output logic                   insert_ready,
  input  logic [KEY_WIDTH-1:0]   insert_key,
  input  logic [DATA_WIDTH-1:0]  insert_data,
  input  logic                   lookup_valid,
  input  logic [KEY_WIDTH-1:0]   lookup_key,
  output logic                   result_valid,
  output logic                   result_hit,
  output logic [INDEX_WIDTH-1:0] result_index,
  output logic [DATA_WIDTH-1:0]  result_data,
  input  logic                   invalidate_valid,
  input  logic [INDEX_WIDTH-1:0] invalidate_index,
  input  logic                   flush,
  output logic                   full,
  output logic                   empty,
  output logic [INDEX_WIDTH:0]   count
);
  localparam int COUNT_WIDTH = INDEX_WIDTH + 1;

  logic [SLOTS-1:0]                valid_reg;
  logic [SLOTS-1:0][KEY_WIDTH-1:0] key_reg;
  logic [DATA_WIDTH-1:0]           data_reg [SLOTS];

  logic                   result_valid_reg;
  logic                   result_hit_reg;
  logic [INDEX_WIDTH-1:0] result_index_reg;
  logic [DATA_WIDTH-1:0]  result_data_reg;

  logic                   lookup_hit, insert_hit, insert_fire;
  logic [INDEX_WIDTH-1:0] lookup_index, insert_index, free_index, insert_slot;
  logic [COUNT_WIDTH-1:0] count_sum;

  matching_encoder #(.SLOTS(SLOTS), .KEY_WIDTH(KEY_WIDTH), .INDEX_WIDTH(INDEX_WIDTH)) u_lookup_enc (
    .key(lookup_key), .slot_valid(valid_reg), .slot_keys(key_reg),
    .hit(lookup_hit), .index(lookup_index)
  );

  matching_encoder #(.SLOTS(SLOTS), .KEY_WIDTH(KEY_WIDTH), .INDEX_WIDTH(INDEX_WIDTH)) u_insert_enc (
    .key(insert_key), .slot_valid(valid_reg), .slot_keys(key_reg),
    .hit(insert_hit), .index(insert_index)
  );

  // Descending scan: the lowest free slot is the last one assigned.
  always_comb begin
    free_index = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!valid_reg[i]) free_index = INDEX_WIDTH'(i);
    end
  end

  always_comb begin
    count_sum = '0;
    for (int i = 0; i < SLOTS; i++) begin
      count_sum = count_sum + COUNT_WIDTH'(valid_reg[i]);
    end
  end

  assign count        = count_sum;
  assign full         = (count_sum == COUNT_WIDTH'(SLOTS));
  assign empty        = (count_sum == '0);
  assign insert_ready = (!full || insert_hit) && !flush;
  assign insert_fire  = insert_valid && insert_ready;
  assign insert_slot  = insert_hit ? insert_index : free_index;

  generate
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
      // Flush overrides everything; insert beats invalidate on the same slot.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          valid_reg[gi] <= 1'b0;
        end else if (flush) begin
          valid_reg[gi] <= 1'b0;
        end else if (insert_fire && insert_slot == INDEX_WIDTH'(gi)) begin
          valid_reg[gi] <= 1'b1;
        end else if (invalidate_valid && invalidate_index == INDEX_WIDTH'(gi)) begin
          valid_reg[gi] <= 1'b0;
        end
      end

      always_ff @(posedge clock) begin
        if (insert_fire && insert_slot == INDEX_WIDTH'(gi)) begin
          key_reg[gi]  <= insert_key;
          data_reg[gi] <= insert_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      result_valid_reg <= 1'b0;
      result_hit_reg   <= 1'b0;
      result_index_reg <= '0;
      result_data_reg  <= '0;
    end else begin
      result_valid_reg <= lookup_valid;
      if (lookup_valid) begin
        result_hit_reg   <= lookup_hit;
        result_index_reg <= lookup_hit ? lookup_index : '0;
        result_data_reg  <= lookup_hit ? data_reg[lookup_index] : '0;
      end
    end
  end

  assign result_valid = result_valid_reg;
  assign result_hit   = result_hit_reg;
  assign result_index = result_index_reg;
  assign result_data  = result_data_reg;
endmodule
